// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC SPI responder and its consumer.
// Holds the FSM state encoding and the SPI mode settings.
package adc_pkg;

    localparam int ADC_DATA_W = 12;

    // SPI mode 0: SCLK idles low, MISO sampled on rising edge, MSB first
    localparam bit SPI_CPOL        = 1'b0;
    localparam bit SPI_SAMPLE_RISE = 1'b1;
    localparam bit SPI_MSB_FIRST   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        RDY   = 2'd3
    } adc_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// Request/ready sample bus between the averaging front-end and the responder.
// The consumer drives the request; the responder drives data and ready.
interface adc_spi_responder_if
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
);

    logic              adc_data_req;
    logic              adc_data_rdy;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output adc_data_req,
        input  adc_data_rdy,
        input  adc_data
    );

    modport slave (
        input  adc_data_req,
        output adc_data_rdy,
        output adc_data
    );

endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider for the ADC SPI link: toggles SCLK every CLK_DIV cycles
// while enabled and counts falling edges to find the last bit.
module adc_sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = ADC_DATA_W
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic last_bit_o
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W + 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             half;

    assign half        = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_tick_o = half && !sclk_q;
    assign fall_tick_o = half && sclk_q;
    assign last_bit_o  = (bit_q == BIT_W'(DATA_W - 1));
    assign sclk_o      = sclk_q;

    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            bit_d  = '0;
            sclk_d = SPI_CPOL;
        end else if (half) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                bit_d = bit_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side responder: on request runs a burst of SPI conversions and
// presents each 12-bit result with a ready pulse to the averaging block.
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int DATA_W      = ADC_DATA_W,
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 4,
    parameter int RDY_CYCLES  = 2,
    parameter int BURST_LEN   = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    adc_spi_responder_if.slave  adc_bus,
    output logic                spi_cs_n_o,
    output logic                spi_sclk_o,
    input  logic                spi_miso_i,
    output logic                busy_o
);

    localparam int PH_MAX  = (CONV_CYCLES > RDY_CYCLES) ? CONV_CYCLES : RDY_CYCLES;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int BURST_W = $clog2(BURST_LEN + 1);

    adc_state_e        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;

    logic rise_tick;
    logic fall_tick;
    logic last_bit;
    logic sample_tick;
    logic shift_done;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_sclk (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (state_q == SHIFT),
        .sclk_o      (spi_sclk_o),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick),
        .last_bit_o  (last_bit)
    );

    assign sample_tick = SPI_SAMPLE_RISE ? rise_tick : fall_tick;
    // Sample is complete once SCLK has returned low after the last bit
    assign shift_done  = fall_tick && last_bit;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        burst_d = burst_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (adc_bus.adc_data_req) begin
                    state_d = CONV;
                    ph_d    = '0;
                    burst_d = '0;
                end
            end
            CONV: begin
                if (ph_q == PH_W'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            SHIFT: begin
                if (sample_tick) begin
                    if (SPI_MSB_FIRST) begin
                        shreg_d = {shreg_q[DATA_W-2:0], spi_miso_i};
                    end else begin
                        shreg_d = {spi_miso_i, shreg_q[DATA_W-1:1]};
                    end
                end
                if (shift_done) begin
                    state_d = RDY;
                    data_d  = shreg_q;
                    ph_d    = '0;
                end
            end
            RDY: begin
                if (ph_q == PH_W'(RDY_CYCLES - 1)) begin
                    ph_d    = '0;
                    burst_d = burst_q + 1'b1;
                    if (burst_q == BURST_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CONV;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
        endcase
        rdy_d  = (state_d == RDY);
        cs_n_d = (state_d != SHIFT);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ph_q    <= '0;
            burst_q <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            burst_q <= burst_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
        end
    end

    assign adc_bus.adc_data_rdy = rdy_q;
    assign adc_bus.adc_data     = data_q;
    assign spi_cs_n_o           = cs_n_q;
    assign busy_o               = busy_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder with a behavioural SPI ADC model.
// Sample tables hold the ADC words and the expected parallel results.
module tb_adc_spi_responder;
    import adc_pkg::*;

    localparam int W = ADC_DATA_W;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic spi_miso_i = 1'b0;
    logic spi_cs_n_o;
    logic spi_sclk_o;
    logic busy_o;

    adc_spi_responder_if #(.DATA_W(W)) bus ();

    adc_spi_responder #(
        .DATA_W      (W),
        .CLK_DIV     (2),
        .CONV_CYCLES (4),
        .RDY_CYCLES  (2),
        .BURST_LEN   (8)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .adc_bus    (bus.slave),
        .spi_cs_n_o (spi_cs_n_o),
        .spi_sclk_o (spi_sclk_o),
        .spi_miso_i (spi_miso_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tab[8];

    // ADC model: loads a word on CS fall, shifts out MSB first on SCLK falls
    logic [W-1:0] adc_words[8];
    int           adc_idx = 0;
    logic [W-1:0] cur = '0;
    int           bitn = 0;
    logic         prev_cs = 1'b1;
    logic         prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n_o) begin
            cur = adc_words[adc_idx % 8];
            adc_idx++;
            bitn = W - 1;
            spi_miso_i = cur[W-1];
        end else if (prev_sclk && !spi_sclk_o && !spi_cs_n_o && bitn > 0) begin
            bitn--;
            spi_miso_i = cur[bitn];
        end
        prev_cs = spi_cs_n_o;
        prev_sclk = spi_sclk_o;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int           rise_r[16];
    int           width[16];
    logic [W-1:0] fall_d[16];
    int           npulse;

    // mode 0: 8-cycle req pulse, 1: plus re-pulses, 2: req held high
    task automatic run_burst(input int mode);
        logic prev_rdy;
        prev_rdy = 1'b0;
        npulse = 0;
        for (int i = 0; i < 16; i++) begin
            rise_r[i] = -1;
            width[i] = 0;
            fall_d[i] = 'x;
        end
        for (int k = 0; k < 8; k++) adc_words[k] = tab[k].word;
        adc_idx = 0;
        @(posedge clk);
        #1;
        for (int r = -1; r < 440; r++) begin
            case (mode)
                0: bus.adc_data_req = (r < 7);
                1: bus.adc_data_req = (r < 7) || (r >= 100 && r < 103)
                                      || (r >= 300 && r < 303);
                default: bus.adc_data_req = 1'b1;
            endcase
            @(negedge clk);
            if (bus.adc_data_rdy && !prev_rdy && npulse < 16) begin
                rise_r[npulse] = r;
                npulse++;
            end
            if (bus.adc_data_rdy && npulse > 0) width[npulse-1]++;
            if (!bus.adc_data_rdy && prev_rdy && npulse > 0)
                fall_d[npulse-1] = bus.adc_data;
            prev_rdy = bus.adc_data_rdy;
            if (mode != 2) begin
                if (r == 3) check("cs_n high t0+3", spi_cs_n_o, 1);
                if (r == 4) check("cs_n low t0+4", spi_cs_n_o, 0);
                if (r == 5) check("sclk low t0+5", spi_sclk_o, 0);
                if (r == 6) check("sclk rise t0+6", spi_sclk_o, 1);
                if (r == 431) check("busy t0+431", busy_o, 1);
                if (r == 432) check("busy t0+432", busy_o, 0);
            end else begin
                if (r == 432) check("held idle busy", busy_o, 0);
                if (r == 433) check("held conv busy", busy_o, 1);
                if (r == 433) check("held conv cs_n", spi_cs_n_o, 1);
                if (r == 437) check("held 2nd cs_n", spi_cs_n_o, 0);
            end
            @(posedge clk);
            #1;
        end
        bus.adc_data_req = 1'b0;
        check("pulse count", npulse, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rise[%0d]", k), rise_r[k], 52 + 54 * k);
            check($sformatf("width[%0d]", k), width[k], 2);
            check($sformatf("data[%0d]", k), fall_d[k], tab[k].exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.adc_data_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tab[k].word = 12'hA5C;
            tab[k].exp  = 12'hA5C;
            adc_words[k] = 12'hA5C;
        end

        // Reset held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rdy", bus.adc_data_rdy, 0);
        check("rst data", bus.adc_data, 0);
        check("rst cs_n", spi_cs_n_o, 1);
        check("rst sclk", spi_sclk_o, 0);
        check("rst busy", busy_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;

        // Reset asserted mid-SHIFT while SCLK is high
        adc_idx = 0;
        @(posedge clk);
        #1 bus.adc_data_req = 1'b1;
        @(posedge clk);
        #1 bus.adc_data_req = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);
        check("pre sclk", spi_sclk_o, 1);
        check("pre cs_n", spi_cs_n_o, 0);
        #2 reset_i = 1'b1;
        #1;
        check("async cs_n", spi_cs_n_o, 1);
        check("async sclk", spi_sclk_o, 0);
        check("async rdy", bus.adc_data_rdy, 0);
        check("async data", bus.adc_data, 0);
        check("async busy", busy_o, 0);
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;

        // Constant word burst
        run_burst(0);
        repeat (5) @(posedge clk);

        // Bit-order patterns
        tab[0] = '{12'h800, 12'h800};
        tab[1] = '{12'h001, 12'h001};
        tab[2] = '{12'hFFF, 12'hFFF};
        tab[3] = '{12'h000, 12'h000};
        tab[4] = '{12'h555, 12'h555};
        tab[5] = '{12'hAAA, 12'hAAA};
        tab[6] = '{12'h123, 12'h123};
        tab[7] = '{12'hFED, 12'hFED};
        run_burst(0);
        repeat (5) @(posedge clk);

        // Request re-pulsed mid-burst is ignored
        run_burst(1);
        repeat (5) @(posedge clk);

        // Request held: one IDLE cycle then the next burst starts
        run_burst(2);
        #1 reset_i = 1'b1;
        @(negedge clk);
        check("rst2 cs_n", spi_cs_n_o, 1);
        check("rst2 busy", busy_o, 0);
        check("rst2 rdy", bus.adc_data_rdy, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post idle busy", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
